// File: rtl/env_adsr.sv
// rtl/env_adsr.sv - ADSR envelope generator scaling MIDI velocity for the NCO
module env_adsr #(
    parameter int TICK_DIV     = 1024,
    parameter int ATTACK_STEP  = 4,
    parameter int DECAY_STEP   = 1,
    parameter int SUSTAIN_LVL  = 96,
    parameter int RELEASE_STEP = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic [6:0] NOTE_NUM,
    input  logic [6:0] NOTE_VEL,
    output logic [6:0] VEL_OUT,
    output logic [2:0] STATE,
    output logic       ACTIVE
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    level_q, level_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          gate_q;
    logic [6:0]    note_q, note_d;
    logic [6:0]    vel_q, vel_d;
    logic [6:0]    vel_out_q;
    logic          active_q;

    logic          gate;
    logic          tick;
    logic [7:0]    attack_sum;
    logic [13:0]   prod;

    assign gate       = (NOTE_VEL != 7'd0);
    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign attack_sum = {1'b0, level_q} + 8'(ATTACK_STEP);
    assign prod       = {7'd0, level_q} * {7'd0, vel_q};

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        note_d  = note_q;
        vel_d   = vel_q;
        presc_d = tick ? '0 : presc_q + 1'b1;

        // Note events pre-empt the tick so level never jumps on the same cycle.
        if (gate && !gate_q) begin
            note_d  = NOTE_NUM;
            vel_d   = NOTE_VEL;
            state_d = S_ATTACK;
        end else if (!gate && gate_q) begin
            state_d = S_RELEASE;
        end else if (gate && gate_q && NOTE_NUM != note_q) begin
            note_d  = NOTE_NUM;
            vel_d   = NOTE_VEL;
            state_d = S_ATTACK;
        end else if (gate && gate_q && NOTE_VEL != vel_q) begin
            vel_d = NOTE_VEL;
        end else if (tick) begin
            case (state_q)
                S_IDLE: level_d = 7'd0;
                S_ATTACK: begin
                    if (attack_sum >= 8'd127) begin
                        level_d = 7'd127;
                        state_d = S_DECAY;
                    end else begin
                        level_d = attack_sum[6:0];
                    end
                end
                S_DECAY: begin
                    if ({1'b0, level_q} <= 8'(SUSTAIN_LVL + DECAY_STEP)) begin
                        level_d = 7'(SUSTAIN_LVL);
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = level_q - 7'(DECAY_STEP);
                    end
                end
                S_SUSTAIN: level_d = level_q;
                S_RELEASE: begin
                    if ({1'b0, level_q} <= 8'(RELEASE_STEP)) begin
                        level_d = 7'd0;
                        state_d = S_IDLE;
                    end else begin
                        level_d = level_q - 7'(RELEASE_STEP);
                    end
                end
                default: begin
                    level_d = 7'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            level_q   <= 7'd0;
            presc_q   <= '0;
            gate_q    <= 1'b0;
            note_q    <= 7'd0;
            vel_q     <= 7'd0;
            vel_out_q <= 7'd0;
            active_q  <= 1'b0;
        end else if (CE) begin
            state_q   <= state_d;
            level_q   <= level_d;
            presc_q   <= presc_d;
            gate_q    <= gate;
            note_q    <= note_d;
            vel_q     <= vel_d;
            vel_out_q <= 7'(prod >> 7);
            active_q  <= (state_d != S_IDLE);
        end
    end

    assign VEL_OUT = vel_out_q;
    assign STATE   = state_q;
    assign ACTIVE  = active_q;

endmodule

// File: tb/tb_env_adsr.sv
// tb/tb_env_adsr.sv - self-checking bench for env_adsr against an arithmetic envelope model
module tb_env_adsr;

    localparam int TD = 4;
    localparam int AS = 32;
    localparam int DS = 8;
    localparam int SL = 96;
    localparam int RS = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE = 1'b1;
    logic [6:0] NOTE_NUM = 7'd0;
    logic [6:0] NOTE_VEL = 7'd0;
    logic [6:0] VEL_OUT;
    logic [2:0] STATE;
    logic       ACTIVE;

    env_adsr #(
        .TICK_DIV(TD), .ATTACK_STEP(AS), .DECAY_STEP(DS),
        .SUSTAIN_LVL(SL), .RELEASE_STEP(RS)
    ) dut (
        .CLK(CLK), .RST(RST), .CE(CE),
        .NOTE_NUM(NOTE_NUM), .NOTE_VEL(NOTE_VEL),
        .VEL_OUT(VEL_OUT), .STATE(STATE), .ACTIVE(ACTIVE)
    );

    always #5 CLK = ~CLK;

    int assert_count = 0;
    int fail_count = 0;

    // Envelope model: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    int m_st, m_lvl, m_cnt, m_gate, m_note, m_vel, m_out;
    int cur_num, cur_vel;

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit ce, input int num, input int vel);
        int g;
        int nxt_out;
        if (rst) begin
            m_st = 0; m_lvl = 0; m_cnt = 0; m_gate = 0;
            m_note = 0; m_vel = 0; m_out = 0;
        end else if (ce) begin
            nxt_out = (m_lvl * m_vel) / 128;
            g = (vel != 0);
            if (g && !m_gate) begin
                m_note = num; m_vel = vel; m_st = 1;
            end else if (!g && m_gate) begin
                m_st = 4;
            end else if (g && m_gate && num != m_note) begin
                m_note = num; m_vel = vel; m_st = 1;
            end else if (g && m_gate && vel != m_vel) begin
                m_vel = vel;
            end else if (m_cnt == TD - 1) begin
                if (m_st == 1) begin
                    m_lvl = imin(m_lvl + AS, 127);
                    if (m_lvl == 127) m_st = 2;
                end else if (m_st == 2) begin
                    m_lvl = imax(m_lvl - DS, SL);
                    if (m_lvl == SL) m_st = 3;
                end else if (m_st == 4) begin
                    m_lvl = imax(m_lvl - RS, 0);
                    if (m_lvl == 0) m_st = 0;
                end
            end
            m_gate = g;
            m_cnt = (m_cnt + 1) % TD;
            m_out = nxt_out;
        end
    endtask

    task automatic step(input bit rst, input bit ce, input int num, input int vel);
        RST = rst; CE = ce;
        NOTE_NUM = 7'(num); NOTE_VEL = 7'(vel);
        cur_num = num; cur_vel = vel;
        model_step(rst, ce, num, vel);
        @(posedge CLK); #1;
        chk("state", 32'(STATE), 32'(m_st));
        chk("vel_out", 32'(VEL_OUT), 32'(m_out));
        chk("active", 32'(ACTIVE), 32'(m_st != 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, cur_num, cur_vel);
    endtask

    initial begin
        int found;
        int saved_st, saved_out;

        // Reset held with a live note, then rise on first enabled cycle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 60, 100);
        chk("reset_state", 32'(STATE), 32'd0);
        chk("reset_vel_out", 32'(VEL_OUT), 32'd0);
        chk("reset_active", 32'(ACTIVE), 32'd0);
        step(1'b0, 1'b1, 60, 100);
        chk("post_reset_attack", 32'(STATE), 32'd1);

        // Attack / decay / sustain
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 0, 0);
        step(1'b0, 1'b1, 60, 127);
        run(40);
        chk("sustain_state", 32'(STATE), 32'd3);
        chk("sustain_vel_out", 32'(VEL_OUT), 32'd95);
        run(40);
        chk("sustain_hold", 32'(VEL_OUT), 32'd95);

        // Velocity-only change
        step(1'b0, 1'b1, 60, 64);
        run(2);
        chk("velchg_state", 32'(STATE), 32'd3);
        chk("velchg_vel_out", 32'(VEL_OUT), 32'd48);
        step(1'b0, 1'b1, 60, 127);
        run(3);

        // Retrigger to a new note
        step(1'b0, 1'b1, 64, 100);
        chk("retrig_attack", 32'(STATE), 32'd1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            run(1);
            if (STATE === 3'd2) found = 1;
        end
        chk("retrig_decay_reached", 32'(found), 32'd1);
        run(1);
        chk("retrig_vel_out", 32'(VEL_OUT), 32'd99);

        // Release from sustain
        run(40);
        chk("pre_release_sustain", 32'(STATE), 32'd3);
        step(1'b0, 1'b1, 64, 0);
        chk("release_state", 32'(STATE), 32'd4);
        run(30);
        chk("release_idle", 32'(STATE), 32'd0);
        chk("release_vel_out", 32'(VEL_OUT), 32'd0);
        chk("release_active", 32'(ACTIVE), 32'd0);

        // Release during attack at level 64
        step(1'b0, 1'b1, 50, 127);
        for (int i = 0; i < 20 && m_lvl != 64; i++) run(1);
        step(1'b0, 1'b1, 50, 0);
        chk("rel_attack_state", 32'(STATE), 32'd4);
        run(17);
        chk("rel_attack_idle", 32'(STATE), 32'd0);

        // CE gating mid-attack
        step(1'b0, 1'b1, 70, 120);
        run(5);
        saved_st = m_st;
        saved_out = m_out;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, (i * 7) % 128, i % 3);
        chk("ce_freeze_state", 32'(STATE), 32'(saved_st));
        chk("ce_freeze_vel_out", 32'(VEL_OUT), 32'(saved_out));
        step(1'b0, 1'b1, 70, 120);
        run(30);

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6) begin
                cur_num = 60 + $urandom_range(0, 3);
                cur_vel = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 127);
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, cur_num, cur_vel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/env_adsr.md
Name: env_adsr

Overview:
- ADSR envelope generator between the MIDI decoder and the NCO.
- Watches the decoded NOTE_NUM/NOTE_VEL pair, derives a gate (velocity non-zero) and runs an attack/decay/sustain/release amplitude envelope.
- Outputs a velocity-scaled 7-bit amplitude, VEL_OUT, which drives the NCO NOTE_VEL input in place of the raw MIDI velocity.

Parameters:
- TICK_DIV, 1024: enabled clock cycles per envelope step tick (>=1).
- ATTACK_STEP, 4: level increment per tick in ATTACK (1..127).
- DECAY_STEP, 1: level decrement per tick in DECAY (1..127).
- SUSTAIN_LVL, 96: sustain level (0..127).
- RELEASE_STEP, 2: level decrement per tick in RELEASE (1..127).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CE  in  1  clock enable; when low all registers hold
- NOTE_NUM  in  7  current note from MIDI decoder
- NOTE_VEL  in  7  current velocity from MIDI decoder; 0 = note off
- VEL_OUT  out  7  envelope-scaled velocity to NCO
- STATE  out  3  envelope state: 0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
- ACTIVE  out  1  high whenever STATE != IDLE

Behaviour:
- Single clock CLK. RST is synchronous and active-high and has priority over CE.
- Reset values: STATE=IDLE, level=0, prescaler=0, gate_q=0, note_q=0, vel_q=0, VEL_OUT=0, ACTIVE=0.
- All updates occur only on cycles with CE=1.
- Gate derivation:
  - gate = (NOTE_VEL != 0).
  - gate_q holds the previous enabled-cycle gate.
  - note_q and vel_q hold the latched note and velocity.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 on the enabled cycle where the count equals TICK_DIV-1.
  - The prescaler free-runs and is never reset by note events.
- Event priority in one enabled cycle (highest first):
  - Rise (gate & !gate_q): latch note_q/vel_q, STATE=ATTACK. level is kept (no click); the tick is ignored this cycle.
  - Fall (!gate & gate_q): STATE=RELEASE from any state. level and vel_q are kept; the tick is ignored.
  - Retrigger (gate & gate_q & NOTE_NUM != note_q): latch note_q/vel_q, STATE=ATTACK, level kept.
  - Velocity change (gate & gate_q & same note & NOTE_VEL != vel_q): update vel_q only, no state change.
  - Tick: perform the state step below.
- State steps on tick. level is 7-bit, 0..127; all arithmetic uses 8-bit intermediates with saturation.
  - IDLE: level held at 0.
  - ATTACK: level = min(level+ATTACK_STEP, 127). If the result is 127, go to DECAY.
  - DECAY: level = max(level-DECAY_STEP, SUSTAIN_LVL). If the result equals SUSTAIN_LVL, go to SUSTAIN.
  - DECAY when SUSTAIN_LVL=127: the first DECAY tick goes straight to SUSTAIN.
  - SUSTAIN: level held.
  - RELEASE: level = max(level-RELEASE_STEP, 0). If the result is 0, go to IDLE.
- Output:
  - VEL_OUT = (level * vel_q) >> 7, computed as a 14-bit product with the top 7 bits taken.
  - VEL_OUT is registered, so it lags level by one enabled cycle.
- ACTIVE is registered alongside STATE.
- CE low: prescaler, state, level, latches and outputs all hold. Input changes are evaluated on the next enabled cycle; level-based detection means no event is lost.
- Reset mid-envelope: next cycle is IDLE with level 0. If gate is already high after reset, a rise is detected on the first enabled cycle (gate_q=0).

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, ATTACK_STEP=32, DECAY_STEP=8, SUSTAIN_LVL=96, RELEASE_STEP=16; CE=1 unless stated.
- Reset: RST=1 for 3 cycles with NOTE_VEL=100 -> STATE=0, VEL_OUT=0, ACTIVE=0. One enabled cycle after release -> STATE=ATTACK.
- Attack/decay/sustain: NOTE_NUM=60, NOTE_VEL=127 from IDLE:
  - Level over successive ticks: 32, 64, 96, 127.
  - DECAY ticks: 119, 111, 103, 96.
  - Then SUSTAIN; VEL_OUT settles at (96*127)>>7=95; no further change over 40 cycles.
- Release: from SUSTAIN level 96, set NOTE_VEL=0:
  - STATE=RELEASE on the next cycle.
  - Level 80, 64, 48, 32, 16, 0 on successive ticks, then IDLE, ACTIVE=0, VEL_OUT=0.
- Retrigger: in SUSTAIN with note 60, change NOTE_NUM to 64 with velocity 100:
  - STATE=ATTACK from level 96 with vel_q=100.
  - Next ticks give 127, then DECAY; at level 127 VEL_OUT=(127*100)>>7=99.
- Velocity-only change and release-during-attack:
  - In SUSTAIN, change NOTE_VEL 127->64 -> state stays SUSTAIN, VEL_OUT becomes (96*64)>>7=48.
  - Gate falling at attack level 64 -> RELEASE from 64, IDLE after 4 ticks.
- CE gating: hold CE=0 for 20 cycles mid-ATTACK -> level, STATE and VEL_OUT frozen. After CE returns, the tick cadence resumes from the held prescaler count.
